// File: rtl/mem_stage.sv
// Memory-access stage: word/byte loads and stores against an internal data memory,
// feeding the MEM/WB pipeline register consumed by write-back.
module mem_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmld,
  input  logic        dmsel,
  input  logic        dmstr,
  input  logic [31:0] aluout,
  input  logic [31:0] rfd2,
  input  logic [31:0] pc,
  input  logic [31:0] IR,
  output logic        dmld_wb,
  output logic [31:0] memout_wb,
  output logic [31:0] aluout_wb,
  output logic [31:0] pc_wb,
  output logic [31:0] IR_wb
);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [31:0]       load_data;

  // Address bits above the memory size are dropped, so addresses wrap.
  assign widx    = aluout[ADDR_W+1:2];
  assign lane    = aluout[1:0];
  assign rd_word = mem[widx];

  logic unused_addr;
  assign unused_addr = ^aluout[31:ADDR_W+2];

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    load_data = rd_word;
    if (dmsel) begin
      unique case (lane)
        2'd0:    load_data = {24'h0, rd_word[7:0]};
        2'd1:    load_data = {24'h0, rd_word[15:8]};
        2'd2:    load_data = {24'h0, rd_word[23:16]};
        default: load_data = {24'h0, rd_word[31:24]};
      endcase
    end
  end

  // NOTE: the data memory is deliberately not reset; a reset port would prevent
  // mapping it onto RAM macros, and software must write before it reads.
  always_ff @(posedge clk) begin
    if (!rst && dmstr) begin
      if (dmsel) begin
        unique case (lane)
          2'd0:    mem[widx][7:0]   <= rfd2[7:0];
          2'd1:    mem[widx][15:8]  <= rfd2[7:0];
          2'd2:    mem[widx][23:16] <= rfd2[7:0];
          default: mem[widx][31:24] <= rfd2[7:0];
        endcase
      end else begin
        mem[widx] <= rfd2;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the same pre-edge values; this is also what gives read-before-write on memout_wb.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmld_wb   <= 1'b0;
      memout_wb <= '0;
      aluout_wb <= '0;
      pc_wb     <= '0;
      IR_wb     <= '0;
    end else begin
      dmld_wb   <= dmld;
      memout_wb <= load_data;
      aluout_wb <= aluout;
      pc_wb     <= pc;
      IR_wb     <= IR;
    end
  end

endmodule
